// File: rtl/piso_serializer.sv
// Parallel-in / serial-out word serializer with a one-cycle GAP marker after each word.
// All outputs are flops updated together with the FSM state.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_x;
    logic             r_frame;
    logic             r_done;

    logic [WIDTH-1:0] w_shifted;
    logic             w_next_bit;
    logic             w_load_bit;

    // Shift direction is fixed at elaboration; the bit that will sit on x_o
    // next is taken from the already-shifted word so x_o can be registered.
    assign w_shifted  = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
    assign w_next_bit = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];
    assign w_load_bit = MSB_FIRST ? data_i[WIDTH-1]    : data_i[0];

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples the
        // pre-edge value of every other flop regardless of statement order.
        if (reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_x     <= 1'b0;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (valid_i) begin
                        r_state <= SHIFT;
                        r_shreg <= data_i;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_frame <= 1'b1;
                        r_x     <= w_load_bit;
                    end
                end
                SHIFT: begin
                    r_shreg <= w_shifted;
                    if (r_cnt == LAST_CNT) begin
                        // Counter parks at its last value; it is cleared on the next load.
                        r_state <= GAP;
                        r_frame <= 1'b0;
                        r_x     <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_x   <= w_next_bit;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_shreg <= '0;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_x     <= 1'b0;
                    r_frame <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign x_o     = r_x;
    assign frame_o = r_frame;
    assign done_o  = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=4): one MSB-first and one
// LSB-first instance, table-driven words plus hand-written corner sequences.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_i;
    logic         valid;
    logic         sel;          // 1 selects the MSB-first instance

    logic ready_m, x_m, frame_m, done_m;
    logic ready_l, x_l, frame_l, done_l;
    logic valid_m, valid_l;
    logic w_ready, w_x, w_frame, w_done;

    assign valid_m = valid & sel;
    assign valid_l = valid & ~sel;
    assign w_ready = sel ? ready_m : ready_l;
    assign w_x     = sel ? x_m     : x_l;
    assign w_frame = sel ? frame_m : frame_l;
    assign w_done  = sel ? done_m  : done_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_m),
        .ready_o(ready_m), .x_o(x_m), .frame_o(frame_m), .done_o(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_l),
        .ready_o(ready_l), .x_o(x_l), .frame_o(frame_l), .done_o(done_l)
    );

    always #5 clk = ~clk;

    // Downstream shift register fed by the MSB-first serial stream.
    logic [W-1:0] ds = '0;
    always @(posedge clk) if (frame_m) ds <= {ds[W-2:0], x_m};

    int n_checks = 0;
    int n_err    = 0;
    bit sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_check(input string name, input logic act);
        bit exp;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %0b", name, act);
        end else begin
            exp = sb_q.pop_front();
            check(name, {31'd0, act}, {31'd0, exp});
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         msb;
        logic [W-1:0] exp_seq;   // first transmitted bit at index W-1
    } vec_t;

    vec_t vecs[7];

    // Called at a negedge with the selected DUT in IDLE; returns at the
    // negedge where that DUT is back in IDLE. Optionally changes data_i and
    // pulses valid during SHIFT, both of which must be ignored.
    task automatic run_word(input vec_t v, input bit disturb);
        sel = v.msb;
        check("ready_idle", {31'd0, w_ready}, 32'd1);
        data_i = v.data;
        valid  = 1'b1;
        for (int i = W - 1; i >= 0; i--) sb_q.push_back(v.exp_seq[i]);
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            check("shift_frame", {31'd0, w_frame}, 32'd1);
            check("shift_ready", {31'd0, w_ready}, 32'd0);
            check("shift_done",  {31'd0, w_done},  32'd0);
            sb_check("shift_bit", w_x);
            if (disturb && k == 0) begin
                data_i = 4'hF;
                valid  = 1'b1;
            end
            if (disturb && k == 1) valid = 1'b0;
            @(negedge clk);
        end
        check("gap_done",  {31'd0, w_done},  32'd1);
        check("gap_frame", {31'd0, w_frame}, 32'd0);
        check("gap_x",     {31'd0, w_x},     32'd0);
        check("gap_ready", {31'd0, w_ready}, 32'd0);
        @(negedge clk);
        check("idle_ready", {31'd0, w_ready}, 32'd1);
        check("idle_done",  {31'd0, w_done},  32'd0);
        check("idle_frame", {31'd0, w_frame}, 32'd0);
        if (v.msb) check("downstream_word", {28'd0, ds}, {28'd0, v.data});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_done;
        vec_t v;

        vecs[0] = '{data: 4'b1010, msb: 1'b1, exp_seq: 4'b1010};
        vecs[1] = '{data: 4'b0001, msb: 1'b0, exp_seq: 4'b1000};
        vecs[2] = '{data: 4'b1100, msb: 1'b1, exp_seq: 4'b1100};
        vecs[3] = '{data: 4'b0110, msb: 1'b0, exp_seq: 4'b0110};
        vecs[4] = '{data: 4'b1011, msb: 1'b0, exp_seq: 4'b1101};
        vecs[5] = '{data: 4'b0001, msb: 1'b1, exp_seq: 4'b0001};
        vecs[6] = '{data: 4'b1111, msb: 1'b1, exp_seq: 4'b1111};

        // Reset held two cycles with valid high: reset wins, nothing accepted.
        sel    = 1'b1;
        reset  = 1'b1;
        valid  = 1'b1;
        data_i = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        check("rst_ready_m", {31'd0, ready_m}, 32'd1);
        check("rst_frame_m", {31'd0, frame_m}, 32'd0);
        check("rst_x_m",     {31'd0, x_m},     32'd0);
        check("rst_done_m",  {31'd0, done_m},  32'd0);
        check("rst_ready_l", {31'd0, ready_l}, 32'd1);
        check("rst_frame_l", {31'd0, frame_l}, 32'd0);

        foreach (vecs[i]) run_word(vecs[i], 1'b0);

        // data_i changes and a stray valid during SHIFT are ignored.
        v = '{data: 4'h9, msb: 1'b1, exp_seq: 4'b1001};
        run_word(v, 1'b1);
        @(negedge clk);
        check("no_queue_frame", {31'd0, w_frame}, 32'd0);
        check("no_queue_ready", {31'd0, w_ready}, 32'd1);

        // valid held high: 4'hC, then 4'h3 once ready returns.
        sel    = 1'b1;
        data_i = 4'hC;
        valid  = 1'b1;
        n_done = 0;
        foreach (vecs[i]) if (i < 0) n_done = 0;
        sb_q.push_back(1'b1); sb_q.push_back(1'b1); sb_q.push_back(1'b0); sb_q.push_back(1'b0);
        sb_q.push_back(1'b0); sb_q.push_back(1'b0); sb_q.push_back(1'b1); sb_q.push_back(1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("b2b_frame", {31'd0, w_frame},
                  {31'd0, ((k < 4) || (k >= 6 && k < 10))});
            check("b2b_ready", {31'd0, w_ready}, {31'd0, (k == 5 || k == 11)});
            check("b2b_done",  {31'd0, w_done},  {31'd0, (k == 4 || k == 10)});
            if (w_frame) sb_check("b2b_bit", w_x);
            else         check("b2b_x_idle", {31'd0, w_x}, 32'd0);
            if (w_done) n_done++;
            if (k == 5)  data_i = 4'h3;
            if (k == 10) valid  = 1'b0;
        end
        check("b2b_done_count", n_done, 32'd2);
        check("b2b_sb_drained", sb_q.size(), 32'd0);

        // Reset during the second bit aborts the word without a done pulse.
        sel    = 1'b1;
        data_i = 4'b1010;
        valid  = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("abort_bit0", {31'd0, w_x}, 32'd1);
        @(negedge clk);
        check("abort_bit1", {31'd0, w_x},     32'd0);
        check("abort_fr1",  {31'd0, w_frame}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_frame", {31'd0, w_frame}, 32'd0);
        check("abort_x",     {31'd0, w_x},     32'd0);
        check("abort_ready", {31'd0, w_ready}, 32'd1);
        check("abort_done",  {31'd0, w_done},  32'd0);
        @(negedge clk);
        check("abort_done_later",  {31'd0, w_done},  32'd0);
        check("abort_frame_later", {31'd0, w_frame}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
